// File: rtl/n0prime_gen.sv
`default_nettype none
// ============================================================================
// Module   : n0prime_gen
// Purpose  : Bit-serial Hensel-lifting generator for the Montgomery constant
//            n0prime = -n^-1 mod 2^DATA_WIDTH; flags an even modulus.
//            Define N0P_SELFCHECK_EN to add a multiply-back result check.
// Revision : 1.0
// ============================================================================
module n0prime_gen #(
    parameter int DATA_LENGTH = 1024,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] n,
    output logic [DATA_WIDTH-1:0]  n0prime,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   check_fail
);

    localparam int W  = DATA_WIDTH;
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] I_ONE  = IW'(1);
    localparam logic [IW-1:0] I_LAST = IW'(W - 1);
    localparam logic [W-1:0]  ONE    = W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ITER   = 3'd1,
        S_FINISH = 3'd2,
        S_ERR    = 3'd3,
        S_CHECK  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    nl_q, nl_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    p_q, p_d;
    logic [IW-1:0]   i_q, i_d;
    logic [W-1:0]    n0p_q, n0p_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            chk_q, chk_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            nl_q    <= '0;
            y_q     <= '0;
            p_q     <= '0;
            i_q     <= '0;
            n0p_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            chk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nl_q    <= nl_d;
            y_q     <= y_d;
            p_q     <= p_d;
            i_q     <= i_d;
            n0p_q   <= n0p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            chk_q   <= chk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        nl_d    = nl_q;
        y_d     = y_q;
        p_d     = p_q;
        i_d     = i_q;
        n0p_d   = n0p_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        chk_d   = chk_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nl_d    = n[W-1:0];
                    y_d     = ONE;
                    p_d     = n[W-1:0];
                    i_d     = I_ONE;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    chk_d   = 1'b0;
                    state_d = n[0] ? S_ITER : S_ERR;
                end
            end
            S_ITER: begin
                // Bit i of p set means the inverse needs bit i; adding nl<<i clears it.
                if (p_q[i_q]) begin
                    y_d = y_q | (ONE << i_q);
                    p_d = p_q + (nl_q << i_q);
                end
                i_d = i_q + I_ONE;
                if (i_q == I_LAST) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                n0p_d = (~y_q) + ONE;
`ifdef N0P_SELFCHECK_EN
                state_d = S_CHECK;
`else
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
`endif
            end
`ifdef N0P_SELFCHECK_EN
            S_CHECK: begin
                chk_d   = |((nl_q * n0p_q) + ONE);
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
`endif
            S_ERR: begin
                // Two-cycle residency: i_q still holds 1 on entry and is used as the delay tick.
                if (i_q == I_ONE) begin
                    i_d = '0;
                end else begin
                    n0p_d   = '0;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    generate
        if (DATA_LENGTH > DATA_WIDTH) begin : g_upper_bits
            logic unused_upper;
            assign unused_upper = ^n[DATA_LENGTH-1:DATA_WIDTH];
        end
    endgenerate

    assign n0prime    = n0p_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign check_fail = chk_q;

endmodule
`default_nettype wire

// File: tb/tb_n0prime_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_n0prime_gen
// Purpose  : Scoreboard bench for n0prime_gen (W=32); honours N0P_SELFCHECK_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_n0prime_gen;

    localparam int DL = 1024;
    localparam int W  = 32;
`ifdef N0P_SELFCHECK_EN
    localparam int LAT_ODD = W + 1;
`else
    localparam int LAT_ODD = W;
`endif
    localparam int LAT_EVEN = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DL-1:0] n;
    logic [W-1:0]  n0prime;
    logic          busy;
    logic          done;
    logic          error;
    logic          check_fail;

    n0prime_gen #(
        .DATA_LENGTH(DL),
        .DATA_WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n         (n),
        .n0prime   (n0prime),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .check_fail(check_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] nl;
        logic [W-1:0] exp;
        logic         err;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [DL-1:0] mk_n(input logic [W-1:0] low);
        logic [DL-1:0] v;
        for (int k = 0; k < DL / 32; k++) v[k*32 +: 32] = $urandom;
        v[W-1:0] = low;
        return v;
    endfunction

    // Newton iteration x <- x*(2 - a*x): independent of the DUT's bit-serial method.
    function automatic logic [W-1:0] neg_inv(input logic [W-1:0] a);
        logic [W-1:0] x;
        logic [W-1:0] two;
        two = 2;
        x   = a;
        for (int k = 0; k < 6; k++) x = x * (two - a * x);
        return (~x) + 1;
    endfunction

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t         e;
        logic         done_prev;
        logic [W-1:0] pr;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                if (done_prev) check("done_width", 1, 0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_n0prime"}, n0prime, e.exp);
                    check({e.name, "_error"}, error, e.err);
                    check({e.name, "_latency"}, cyc - e.acc, e.lat);
                    check({e.name, "_check_fail"}, check_fail, 0);
                    check({e.name, "_busy_low"}, busy, 0);
                    if (!e.err) begin
                        pr = e.nl * n0prime + 1;
                        check({e.name, "_product"}, pr, 0);
                    end
                end
            end
            done_prev = done;
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic push(input logic [W-1:0] low, input logic [W-1:0] exp, input logic err, input string nm);
        exp_t e;
        e.nl   = low;
        e.exp  = exp;
        e.err  = err;
        e.lat  = err ? LAT_EVEN : LAT_ODD;
        e.acc  = cyc;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Drive one request at a negedge; n is scrambled right after the accept edge.
    task automatic issue(input logic [W-1:0] low, input logic [W-1:0] exp, input logic err, input string nm);
        @(negedge clk);
        wait_idle();
        n     = mk_n(low);
        start = 1'b1;
        @(negedge clk);
        push(low, exp, err, nm);
        start = 1'b0;
        n     = mk_n(~low);
        check({nm, "_busy_high"}, busy, 1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        n     = '0;
        repeat (3) @(negedge clk);
        check("rst_n0prime", n0prime, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_check_fail", check_fail, 0);
        reset = 1'b0;

        issue(32'h00000001, 32'hFFFFFFFF, 1'b0, "n1");
        issue(32'h00000003, 32'h55555555, 1'b0, "n3");
        issue(32'h00000005, 32'h33333333, 1'b0, "n5");
        issue(32'h00000007, 32'h49249249, 1'b0, "n7");
        issue(32'h00000009, 32'hC71C71C7, 1'b0, "n9");
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, "nmax_a");
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, "nmax_b");
        issue(32'h00000010, 32'h00000000, 1'b1, "even10");
        issue(32'h00000003, 32'h55555555, 1'b0, "odd_after_even");

        // Start pulse mid-run must be ignored.
        issue(32'h00000007, 32'h49249249, 1'b0, "midstart");
        repeat (9) @(negedge clk);
        start = 1'b1;
        n     = mk_n(32'h00000005);
        @(negedge clk);
        start = 1'b0;

        // Start held high: the next run is accepted on the edge right after done.
        @(negedge clk);
        wait_idle();
        n     = mk_n(32'h00000009);
        start = 1'b1;
        @(negedge clk);
        push(32'h00000009, 32'hC71C71C7, 1'b0, "held_a");
        begin
            int t = 0;
            while (!done && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!done) check("held_done_timeout", 1, 0);
        end
        n = mk_n(32'h00000003);
        @(negedge clk);
        push(32'h00000003, 32'h55555555, 1'b0, "held_b");
        start = 1'b0;

        // Reset in the middle of a run aborts it without a done pulse.
        issue(32'h00000005, 32'h33333333, 1'b0, "aborted");
        repeat (14) @(negedge clk);
        void'(sb.pop_back());
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_n0prime", n0prime, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_error", error, 0);
        check("abort_check_fail", check_fail, 0);
        repeat (40) @(negedge clk);
        issue(32'h00000005, 32'h33333333, 1'b0, "after_abort");

`ifdef N0P_SELFCHECK_EN
        for (int r = 0; r < 1000; r++) begin
            logic [W-1:0] v;
            v    = $urandom;
            v[0] = 1'b1;
            issue(v, neg_inv(v), 1'b0, "rand");
        end
`else
        for (int r = 0; r < 8; r++) begin
            logic [W-1:0] v;
            v    = $urandom;
            v[0] = 1'b1;
            issue(v, neg_inv(v), 1'b0, "rand");
        end
`endif

        begin
            int t = 0;
            while ((sb.size() != 0 || busy) && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        end
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
